// File: rtl/flush_sequencer.sv
// flush_sequencer: pipeline flush strobes plus multi-channel data-cache write-back flush
// sequencing with per-channel ack tracking, single pending fence and timeout abort.
module flush_sequencer #(
  parameter int unsigned          NR_CACHES      = 2,
  parameter logic [NR_CACHES-1:0] WB_MASK        = 'b01,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter int unsigned          CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 mispredict_i,
  input  logic                 fence_i,
  input  logic                 fence_i_i,
  input  logic                 sfence_vma_i,
  input  logic                 flush_csr_i,
  input  logic                 flush_commit_i,
  input  logic                 ex_valid_i,
  input  logic                 eret_i,
  input  logic                 set_debug_pc_i,
  input  logic                 halt_csr_i,
  input  logic [NR_CACHES-1:0] flush_cache_ack_i,
  output logic                 set_pc_commit_o,
  output logic                 flush_if_o,
  output logic                 flush_unissued_instr_o,
  output logic                 flush_id_o,
  output logic                 flush_ex_o,
  output logic                 flush_bp_o,
  output logic                 flush_icache_o,
  output logic                 flush_tlb_o,
  output logic [NR_CACHES-1:0] flush_cache_o,
  output logic                 halt_o,
  output logic                 fence_busy_o,
  output logic                 flush_timeout_o
);
  localparam int unsigned CW = (CNT_W > 0) ? CNT_W : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e               state_q, state_d;
  logic [NR_CACHES-1:0] fc_q, fc_d, ack_q, ack_d, acc;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 pend_q, pend_d, to_q, to_d;
  logic                 fence, done, expire, trap, sync;

  assign trap = ex_valid_i | eret_i | set_debug_pc_i;
  assign sync = fence_i | fence_i_i | sfence_vma_i | flush_csr_i | flush_commit_i;

  // Trap-class flushes redirect the PC themselves, so commit PC+4 is suppressed.
  assign set_pc_commit_o        = sync & ~trap;
  assign flush_if_o             = mispredict_i | sync | trap;
  assign flush_unissued_instr_o = mispredict_i | sync | trap;
  assign flush_id_o             = sync | trap;
  assign flush_ex_o             = sync | trap;
  assign flush_bp_o             = trap;
  assign flush_icache_o         = fence_i_i;
  assign flush_tlb_o            = sfence_vma_i;

  assign flush_cache_o   = fc_q;
  assign fence_busy_o    = (state_q == BUSY);
  assign halt_o          = halt_csr_i | (state_q == BUSY);
  assign flush_timeout_o = to_q;

  always_comb begin
    fence   = fence_i | fence_i_i;
    acc     = flush_cache_ack_i & fc_q;
    done    = ((ack_q | acc) == WB_MASK);
    expire  = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !done;
    state_d = state_q;
    fc_d    = fc_q;
    ack_d   = ack_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (fence && (WB_MASK != '0)) begin
        state_d = BUSY;
        fc_d    = WB_MASK;
        ack_d   = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    end else if (done || expire) begin
      // A fence arriving in the finishing cycle counts as pending and restarts the flush.
      to_d    = expire;
      state_d = (pend_q || fence) ? BUSY : IDLE;
      fc_d    = (pend_q || fence) ? WB_MASK : '0;
      ack_d   = '0;
      cnt_d   = '0;
      pend_d  = 1'b0;
    end else begin
      fc_d   = fc_q & ~acc;
      ack_d  = ack_q | acc;
      cnt_d  = cnt_q + CW'(1);
      pend_d = pend_q | fence;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      fc_q    <= '0;
      ack_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
    end
  end
endmodule
